// File: rtl/sort_pkg.sv
// Shared types and constants for the 11-input sorting path.
//   data_t         : 32-bit word carried through the gather stage and sorter
//   SORT_N         : batch size (slot count), matches the sorting network
//   SORT_PAD       : fill value for unused slots; sorts last under unsigned <=
//   gather_state_t : FILL (collecting words) / HOLD (batch presented)
package sort_pkg;

  typedef logic [31:0] data_t;

  localparam int unsigned SORT_N   = 11;
  localparam data_t       SORT_PAD = '1;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } gather_state_t;

endpackage

// File: rtl/sort_11_gather.sv
// Gather stage feeding the 11-input combinational sorting network.
// Collects up to 11 words from a valid/ready stream into a parallel batch.
// Short batches (closed by in_last) are padded with SORT_PAD. The batch is
// held stable on data_0..data_10 until the consumer accepts it.
//
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_data/in_valid     : input stream word and its qualifier
//   in_last              : final word of a short batch (qualified by in_valid)
//   in_ready             : high in FILL; depends only on registered state
//   data_0..data_10      : batch slots, k-th accepted word or SORT_PAD
//   out_valid/out_ready  : batch handshake
//   out_count            : number of real words in the batch (1..11)
module sort_11_gather
  import sort_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  data_t      in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output data_t      data_0,
  output data_t      data_1,
  output data_t      data_2,
  output data_t      data_3,
  output data_t      data_4,
  output data_t      data_5,
  output data_t      data_6,
  output data_t      data_7,
  output data_t      data_8,
  output data_t      data_9,
  output data_t      data_10,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_count
);

  localparam logic [3:0] LAST_IDX = 4'(SORT_N - 1);

  gather_state_t r_state;
  gather_state_t w_state_nxt;
  logic [3:0]    r_cnt;
  logic [3:0]    r_count;
  data_t         r_slot [SORT_N];

  logic          w_accept;
  logic          w_close;
  logic          w_release;
  logic [SORT_N-1:0] w_wr;
  logic [SORT_N-1:0] w_pad;

  assign in_ready  = (r_state == FILL);
  assign out_valid = (r_state == HOLD);
  assign out_count = r_count;

  assign w_accept  = in_valid && (r_state == FILL);
  assign w_close   = w_accept && ((r_cnt == LAST_IDX) || in_last);
  assign w_release = (r_state == HOLD) && out_ready;

  // Slot k takes the incoming word when cnt==k; slots above cnt are padded
  // in the same cycle a batch is closed early.
  for (genvar k = 0; k < SORT_N; k++) begin : g_slot_en
    assign w_wr[k]  = w_accept && (r_cnt == 4'(k));
    assign w_pad[k] = w_close && (r_cnt < 4'(k));
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FILL:    if (w_close)   w_state_nxt = HOLD;
      HOLD:    if (w_release) w_state_nxt = FILL;
      default: w_state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_count <= '0;
    end else begin
      if (w_close) begin
        r_count <= r_cnt + 4'd1;
      end else if (w_accept) begin
        r_cnt <= r_cnt + 4'd1;
      end
      if (w_release) begin
        r_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < SORT_N; i++) begin
        r_slot[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < SORT_N; i++) begin
        if (w_wr[i]) begin
          r_slot[i] <= in_data;
        end else if (w_pad[i]) begin
          r_slot[i] <= SORT_PAD;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_close) begin
      assert (r_cnt <= LAST_IDX)
        else $error("gather entered HOLD with cnt=%0d", r_cnt);
    end
  end

  assign data_0  = r_slot[0];
  assign data_1  = r_slot[1];
  assign data_2  = r_slot[2];
  assign data_3  = r_slot[3];
  assign data_4  = r_slot[4];
  assign data_5  = r_slot[5];
  assign data_6  = r_slot[6];
  assign data_7  = r_slot[7];
  assign data_8  = r_slot[8];
  assign data_9  = r_slot[9];
  assign data_10 = r_slot[10];

endmodule

// File: tb/tb_sort_11_gather.sv
module tb_sort_11_gather;
  import sort_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  data_t      in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_count;
  data_t      d [SORT_N];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sort_11_gather dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .data_0    (d[0]),
    .data_1    (d[1]),
    .data_2    (d[2]),
    .data_3    (d[3]),
    .data_4    (d[4]),
    .data_5    (d[5]),
    .data_6    (d[6]),
    .data_7    (d[7]),
    .data_8    (d[8]),
    .data_9    (d[9]),
    .data_10   (d[10]),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a list of words accepted so far in the current batch,
  // and the most recently completed batch (which persists until overwritten).
  data_t m_words[$];
  data_t m_data [SORT_N];
  int    m_count = 0;
  bit    m_valid = 0;
  bit    m_live  = 0;
  data_t sb[$];

  always @(posedge clk) begin
    m_live = 1;
    if (rst) begin
      m_words.delete();
      sb.delete();
      m_valid = 0;
      m_count = 0;
      for (int k = 0; k < SORT_N; k++) m_data[k] = '0;
    end else if (m_valid) begin
      if (out_ready) m_valid = 0;
    end else if (in_valid) begin
      m_words.push_back(in_data);
      sb.push_back(in_data);
      if (m_words.size() == SORT_N || in_last) begin
        m_count = m_words.size();
        for (int k = 0; k < SORT_N; k++)
          m_data[k] = (k < m_words.size()) ? m_words[k] : SORT_PAD;
        m_words.delete();
        m_valid = 1;
      end
    end
  end

  // Per-cycle comparison against the model, plus an in-order scoreboard
  // that consumes each released batch's real words.
  always @(negedge clk) begin
    if (m_live) begin
      chk("in_ready", 32'(in_ready), 32'(!m_valid));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("out_count", 32'(out_count), 32'(m_count));
      if (m_valid) begin
        for (int k = 0; k < SORT_N; k++)
          chk($sformatf("data_%0d", k), d[k], m_data[k]);
        if (out_ready && !rst) begin
          for (int k = 0; k < SORT_N; k++) begin
            if (k < int'(out_count)) begin
              if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
              else chk($sformatf("sb_word_%0d", k), d[k], sb.pop_front());
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input data_t w, input logic last);
    in_data  = w;
    in_valid = 1'b1;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic release_batch();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  int sent;
  int cyc;
  bit acc;

  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    step(); step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_data_0", d[0], 32'd0);
    rst = 1'b0;

    // Full batch 11..1
    for (int i = 0; i < 11; i++) begin
      chk("full_out_valid_early", 32'(out_valid), 32'd0);
      send(data_t'(11 - i), 1'b0);
    end
    chk("full_out_valid", 32'(out_valid), 32'd1);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_count", 32'(out_count), 32'd11);
    chk("full_data_0", d[0], 32'd11);
    chk("full_data_10", d[10], 32'd1);
    release_batch();
    chk("full_released", 32'(out_valid), 32'd0);

    // Short batch 5,3,9
    send(32'd5, 1'b0); send(32'd3, 1'b0); send(32'd9, 1'b1);
    chk("short_count", 32'(out_count), 32'd3);
    chk("short_data_2", d[2], 32'd9);
    chk("short_data_3", d[3], 32'hFFFF_FFFF);
    chk("short_data_10", d[10], 32'hFFFF_FFFF);
    release_batch();

    // Single word; in_last alone without in_valid is ignored first
    in_last = 1'b1; step(); in_last = 1'b0;
    chk("lone_last_ignored", 32'(out_valid), 32'd0);
    send(32'd42, 1'b1);
    chk("single_count", 32'(out_count), 32'd1);
    chk("single_data_0", d[0], 32'd42);
    chk("single_data_1", d[1], 32'hFFFF_FFFF);
    release_batch();

    // Backpressure and back-to-back, in_last on the 11th word
    for (int i = 0; i < 11; i++) send(data_t'(200 + i), i == 10);
    chk("bp_count", 32'(out_count), 32'd11);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = data_t'(900 + i);
      step();
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_data_0", d[0], 32'd200);
      chk("bp_hold_data_10", d[10], 32'd210);
    end
    in_data = 32'd300; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("b2b_bubble_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 11; i++) begin
      in_data = data_t'(300 + i);
      step();
    end
    in_valid = 1'b0;
    chk("b2b_count", 32'(out_count), 32'd11);
    chk("b2b_data_0", d[0], 32'd300);
    chk("b2b_data_10", d[10], 32'd310);
    release_batch();

    // Reset mid-fill, with a handshake coincident with reset
    for (int i = 0; i < 6; i++) send(data_t'(50 + i), 1'b0);
    rst = 1'b1; in_valid = 1'b1; in_data = 32'd77;
    step();
    rst = 1'b0; in_valid = 1'b0;
    chk("mid_rst_count", 32'(out_count), 32'd0);
    chk("mid_rst_data_0", d[0], 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 11; i++) send(data_t'(100 + i), 1'b0);
    for (int k = 0; k < SORT_N; k++)
      chk($sformatf("after_rst_data_%0d", k), d[k], data_t'(100 + k));
    chk("after_rst_count", 32'(out_count), 32'd11);
    release_batch();

    // Random stress
    sent = 0; cyc = 0;
    while (sent < 1000 && cyc < 20000) begin
      acc       = !m_valid;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_last   = ($urandom_range(0, 7) == 0);
      in_data   = data_t'(32'h1000 + sent);
      out_ready = ($urandom_range(0, 2) != 0);
      if (in_valid && acc) sent++;
      step();
      cyc++;
    end
    if (sent < 1000) chk("stress_budget", 32'(sent), 32'd1000);
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    step(); step();
    out_ready = 1'b0;
    chk("stress_leftover", 32'(sb.size()), 32'(m_words.size()));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
